pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer: it owns the PC register and computes the next PC each cycle.
- Next PC is one of: sequential +1, PC-relative branch with a sign-extended immediate, or PC-relative branch through a run-time-writable offset LUT.
- It also provides start/halt control and stall.
- It sits between the instruction decoder (branch/halt controls) and instruction memory (PC address); the LUT is loaded by the boot/config path before program start.

Parameters:
- D, 12, PC and offset width in bits; the PC wraps modulo 2^D.
- F, 4, width of the branch field (immediate or LUT index); the LUT has 2^F entries.
- RAS_DEPTH, 4, return-address stack depth; used only when PCSEQ_RAS_EN is defined; must be ≥1.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse: PC:=0, enter RUN.
- Stall  input  1  freeze PC and state this cycle.
- Halt  input  1  current instruction is halt.
- Branch  input  1  current instruction is a conditional branch.
- Taken  input  1  branch condition is true; qualified by Branch.
- ImmOrLUT  input  1  1 = use LUT[Field]; 0 = use sign-extended Field.
- Field  input  F  immediate offset or LUT index.
- Call  input  1  call instruction; target is computed as for a taken branch.
- Ret  input  1  return instruction.
- LutWe  input  1  LUT write enable.
- LutWaddr  input  F  LUT write index.
- LutWdata  input  D  signed offset to store.
- PC  output  D  current program counter.
- Running  output  1  state == RUN.
- Done  output  1  state == HALTED.
- Fault  output  1  sticky return-stack error flag.

Behaviour:
- States: IDLE, RUN, HALTED.
- Reset: state=IDLE, PC=0, Running=0, Done=0, Fault=0, all LUT entries=0, RAS pointer=0.
- IDLE: PC held at 0. Start → RUN, PC=0.
- RUN, evaluated in priority order:
  1. Start → PC=0, stay RUN, Fault cleared.
  2. Stall → hold everything. Halt, Branch, Call and Ret are ignored this cycle.
  3. Halt → HALTED, PC held.
  4. Ret → see Optional Feature.
  5. Call, or Branch&Taken → PC := PC + off.
  6. Otherwise → PC := PC + 1.
- Offset selection: off = ImmOrLUT ? LUT[Field] : sign-extension of Field to D bits.
- Offset arithmetic: all sums are D-bit, modulo 2^D. Wrap-around is legal and silent: 0xFFF + 1 = 0x000 at D=12.
- Offset 0: a taken branch holds the PC (deliberate spin); no error.
- Branch with Taken=0: PC+1.
- Control-input conflicts: when more than one of Halt, Ret, Call, Branch is high, the priority order above decides.
- HALTED: PC frozen, Done=1. Start → RUN, PC=0, Done=0. Stall has no effect.
- Next-PC latency: one cycle. Controls are sampled at edge N; the new PC is visible after edge N. PC is a registered output.
- LUT read: combinational.
- LUT write: takes effect at the edge, in any state, including during Stall.
- Same-cycle LUT write and branch through the same index: the branch uses the pre-write value.
- Reset mid-run (asserted in any state): returns to IDLE next edge, overriding Start and all other inputs.
- Start has no effect while Reset is high.

Optional Feature:
- Macro: PCSEQ_RAS_EN.
- Defined: RAS_DEPTH-entry return-address stack.
  - Call pushes PC+1 and branches.
  - Ret pops into PC.
  - Push when full: branch still taken, return address dropped, Fault:=1.
  - Ret when empty: PC := PC+1, Fault:=1.
  - Stall blocks push and pop.
  - Reset and Start empty the stack; Fault is cleared by Reset or Start only.
- Not defined:
  - Call behaves as a taken branch with no push.
  - Ret behaves as a plain PC+1.
  - Fault is tied to 0 and no stack storage is built.

Test Plan:
- Reset, Start, 5 idle cycles → PC 0,1,2,3,4,5; Running=1, Done=0.
- At PC=20, Branch=1, Taken=1, ImmOrLUT=0, Field=4'b1100 → PC=16. Same with Taken=0 → PC=21.
- Write LUT[13]=-130 (0xF7E). At PC=200, branch with ImmOrLUT=1, Field=13 → PC=70. Write LUT[13]=+9 in the same cycle as that branch → PC still 70. Next branch via index 13 from PC=70 → 79.
- PC=0xFFE, 3 plain cycles → 0xFFF, 0x000, 0x001. Taken branch with LUT entry 0 → PC holds.
- Stall with Halt high for 3 cycles → PC unchanged, Done=0. Release Stall with Halt still high → HALTED, Done=1. Start → PC=0, RUN.
- With PCSEQ_RAS_EN and RAS_DEPTH=2:
  - Calls from PC 10, 30, 50 (offset +10) → Fault=1 after the third call.
  - Two Rets → PC=31, then 11.
  - A third Ret → PC+1.
  - Without the macro, the same Ret → PC+1 and Fault stays 0.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter sequencer: sequential, immediate-relative and
//            LUT-relative next-PC selection with start/halt/stall control.
//            Define PCSEQ_RAS_EN to build the optional return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int D         = 12,
    parameter int F         = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Stall,
    input  logic         Halt,
    input  logic         Branch,
    input  logic         Taken,
    input  logic         ImmOrLUT,
    input  logic [F-1:0] Field,
    input  logic         Call,
    input  logic         Ret,
    input  logic         LutWe,
    input  logic [F-1:0] LutWaddr,
    input  logic [D-1:0] LutWdata,
    output logic [D-1:0] PC,
    output logic         Running,
    output logic         Done,
    output logic         Fault
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nx;
    logic [D-1:0] r_pc;
    logic [D-1:0] w_pc_nx;
    logic [D-1:0] w_imm;
    logic [D-1:0] w_off;
    logic [D-1:0] w_pc_inc;
    logic [D-1:0] w_pc_br;
    logic [D-1:0] r_lut [2**F];

    // Return-stack handshake between the FSM and the (optional) stack
    logic         w_push;
    logic         w_pop;
    logic         w_clear;
    logic         w_fault_set;
    logic         w_ras_empty;
    logic         w_ras_full;
    logic [D-1:0] w_ras_top;

    assign w_imm    = {{(D-F){Field[F-1]}}, Field};
    assign w_off    = ImmOrLUT ? r_lut[Field] : w_imm;
    assign w_pc_inc = r_pc + D'(1);
    assign w_pc_br  = r_pc + w_off;

    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clear     = 1'b0;
        w_fault_set = 1'b0;
        case (r_state)
            S_RUN: begin
                if (Start) begin
                    w_pc_nx = '0;
                    w_clear = 1'b1;
                end else if (Stall) begin
                    w_pc_nx = r_pc;
                end else if (Halt) begin
                    w_state_nx = S_HALTED;
                end else if (Ret) begin
                    if (!w_ras_empty) begin
                        w_pc_nx = w_ras_top;
                        w_pop   = 1'b1;
                    end else begin
                        w_pc_nx     = w_pc_inc;
                        w_fault_set = 1'b1;
                    end
                end else if (Call || (Branch && Taken)) begin
                    w_pc_nx = w_pc_br;
                    if (Call) begin
                        if (w_ras_full) w_fault_set = 1'b1;
                        else            w_push      = 1'b1;
                    end
                end else begin
                    w_pc_nx = w_pc_inc;
                end
            end
            default: begin
                // IDLE and HALTED both wait for Start
                if (Start) begin
                    w_state_nx = S_RUN;
                    w_pc_nx    = '0;
                    w_clear    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
        end
    end

    // Reads above see the pre-write entry when a write hits the same index
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 2**F; i++) r_lut[i] <= '0;
        end else if (LutWe) begin
            r_lut[LutWaddr] <= LutWdata;
        end
    end

`ifdef PCSEQ_RAS_EN
    localparam int SP_W  = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [D-1:0]     r_ras [2**IDX_W];
    logic [SP_W-1:0]  r_sp;
    logic             r_fault;
    logic [IDX_W-1:0] w_push_idx;
    logic [IDX_W-1:0] w_top_idx;

    assign w_push_idx  = IDX_W'(r_sp);
    assign w_top_idx   = IDX_W'(r_sp - SP_W'(1));
    assign w_ras_empty = (r_sp == '0);
    assign w_ras_full  = (r_sp == SP_W'(RAS_DEPTH));
    assign w_ras_top   = r_ras[w_top_idx];
    assign Fault       = r_fault;

    always_ff @(posedge Clk) begin
        if (Reset || w_clear) begin
            r_sp    <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_push)     r_sp <= r_sp + SP_W'(1);
            else if (w_pop) r_sp <= r_sp - SP_W'(1);
            if (w_fault_set) r_fault <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && !w_clear && w_push) r_ras[w_push_idx] <= w_pc_inc;
    end
`else
    logic w_unused_ras;

    // Empty stack makes Ret fall through to PC+1; fault is never raised
    assign w_ras_empty  = 1'b1;
    assign w_ras_full   = 1'b1;
    assign w_ras_top    = '0;
    assign Fault        = 1'b0;
    assign w_unused_ras = ^{w_push, w_pop, w_clear, w_fault_set, 32'(RAS_DEPTH)};
`endif

    assign PC      = r_pc;
    assign Running = (r_state == S_RUN);
    assign Done    = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed and random stimulus for pc_sequencer against a
//            behavioural model. Honours PCSEQ_RAS_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int D       = 12;
    localparam int F       = 4;
    localparam int DEPTH   = 2;
    localparam int MOD     = 4096;
    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_HALT = 2;

    logic         Clk = 1'b0;
    logic         Reset, Start, Stall, Halt, Branch, Taken, ImmOrLUT;
    logic [F-1:0] Field;
    logic         Call, Ret, LutWe;
    logic [F-1:0] LutWaddr;
    logic [D-1:0] LutWdata;
    logic [D-1:0] PC;
    logic         Running, Done, Fault;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_st;
    int m_pc;
    int m_fault;
    int m_lut [16];
    int m_stack [$];

    pc_sequencer #(.D(D), .F(F), .RAS_DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Stall    (Stall),
        .Halt     (Halt),
        .Branch   (Branch),
        .Taken    (Taken),
        .ImmOrLUT (ImmOrLUT),
        .Field    (Field),
        .Call     (Call),
        .Ret      (Ret),
        .LutWe    (LutWe),
        .LutWaddr (LutWaddr),
        .LutWdata (LutWdata),
        .PC       (PC),
        .Running  (Running),
        .Done     (Done),
        .Fault    (Fault)
    );

    always #5 Clk = ~Clk;

    function automatic int wrap(input int v);
        return ((v % MOD) + MOD) % MOD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_restart();
        m_st    = ST_RUN;
        m_pc    = 0;
        m_fault = 0;
        m_stack.delete();
    endtask

    // Applies the sequencer rules to the inputs present at this clock edge
    task automatic model_edge();
        int off;
        if (Reset) begin
            m_st    = ST_IDLE;
            m_pc    = 0;
            m_fault = 0;
            m_stack.delete();
            foreach (m_lut[i]) m_lut[i] = 0;
            return;
        end
        off = ImmOrLUT ? m_lut[Field] : ((int'(Field) >= 8) ? int'(Field) - 16 : int'(Field));
        if (m_st != ST_RUN) begin
            if (Start) model_restart();
        end else if (Start) begin
            model_restart();
        end else if (Stall) begin
            m_pc = m_pc;
        end else if (Halt) begin
            m_st = ST_HALT;
        end else if (Ret) begin
`ifdef PCSEQ_RAS_EN
            if (m_stack.size() > 0) begin
                m_pc = m_stack.pop_back();
            end else begin
                m_pc    = wrap(m_pc + 1);
                m_fault = 1;
            end
`else
            m_pc = wrap(m_pc + 1);
`endif
        end else if (Call || (Branch && Taken)) begin
`ifdef PCSEQ_RAS_EN
            if (Call) begin
                if (m_stack.size() < DEPTH) m_stack.push_back(wrap(m_pc + 1));
                else                        m_fault = 1;
            end
`endif
            m_pc = wrap(m_pc + off);
        end else begin
            m_pc = wrap(m_pc + 1);
        end
        if (LutWe) m_lut[LutWaddr] = int'(LutWdata);
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            model_edge();
            #1;
            chk("pc",      32'(PC),      32'(m_pc));
            chk("running", 32'(Running), 32'(m_st == ST_RUN));
            chk("done",    32'(Done),    32'(m_st == ST_HALT));
            chk("fault",   32'(Fault),   32'(m_fault));
        end
    endtask

    task automatic clear_in();
        Start = 0; Stall = 0; Halt = 0; Branch = 0; Taken = 0; ImmOrLUT = 0;
        Field = '0; Call = 0; Ret = 0; LutWe = 0; LutWaddr = '0; LutWdata = '0;
    endtask

    task automatic pulse_start();
        clear_in(); Start = 1; cyc(1); Start = 0;
    endtask

    task automatic branch(input logic lut, input logic [F-1:0] fld, input logic tk);
        clear_in(); Branch = 1; Taken = tk; ImmOrLUT = lut; Field = fld; cyc(1); clear_in();
    endtask

    task automatic lut_write(input logic [F-1:0] a, input logic [D-1:0] v);
        clear_in(); LutWe = 1; LutWaddr = a; LutWdata = v; cyc(1); clear_in();
    endtask

    task automatic call_lut(input logic [F-1:0] fld);
        clear_in(); Call = 1; ImmOrLUT = 1; Field = fld; cyc(1); clear_in();
    endtask

    task automatic ret_once();
        clear_in(); Ret = 1; cyc(1); clear_in();
    endtask

    initial begin
        m_st = ST_IDLE; m_pc = 0; m_fault = 0;
        foreach (m_lut[i]) m_lut[i] = 0;
        clear_in();
        Reset = 1;

        // Reset and idle
        cyc(2);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_running", 32'(Running), 32'd0);
        chk("rst_fault", 32'(Fault), 32'd0);
        Reset = 0;
        cyc(1);
        chk("idle_pc", 32'(PC), 32'd0);

        // Start and sequential counting
        pulse_start();
        chk("start_pc", 32'(PC), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            chk("seq_pc", 32'(PC), 32'(i));
        end
        chk("seq_running", 32'(Running), 32'd1);
        chk("seq_done", 32'(Done), 32'd0);

        // Immediate branch, taken and not taken
        cyc(15);
        chk("at20", 32'(PC), 32'd20);
        branch(1'b0, 4'b1100, 1'b1);
        chk("br_imm_taken", 32'(PC), 32'd16);
        cyc(4);
        branch(1'b0, 4'b1100, 1'b0);
        chk("br_not_taken", 32'(PC), 32'd21);

        // LUT branch, including same-cycle rewrite of the used entry
        lut_write(4'd13, 12'hF7E);
        lut_write(4'd0, 12'd200);
        pulse_start();
        branch(1'b1, 4'd0, 1'b1);
        chk("br_to_200", 32'(PC), 32'd200);
        branch(1'b1, 4'd13, 1'b1);
        chk("br_lut_neg", 32'(PC), 32'd70);
        pulse_start();
        branch(1'b1, 4'd0, 1'b1);
        clear_in();
        Branch = 1; Taken = 1; ImmOrLUT = 1; Field = 4'd13;
        LutWe = 1; LutWaddr = 4'd13; LutWdata = 12'd9;
        cyc(1);
        chk("br_prewrite", 32'(PC), 32'd70);
        branch(1'b1, 4'd13, 1'b1);
        chk("br_lut_pos", 32'(PC), 32'd79);

        // Wrap-around and zero-offset spin
        lut_write(4'd1, 12'hFFE);
        pulse_start();
        branch(1'b1, 4'd1, 1'b1);
        chk("at_ffe", 32'(PC), 32'hFFE);
        cyc(1); chk("wrap0", 32'(PC), 32'hFFF);
        cyc(1); chk("wrap1", 32'(PC), 32'h000);
        cyc(1); chk("wrap2", 32'(PC), 32'h001);
        branch(1'b1, 4'd2, 1'b1);
        chk("spin", 32'(PC), 32'h001);

        // Stall masks Halt, then halt, then restart
        clear_in(); Stall = 1; Halt = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("stall_pc", 32'(PC), 32'h001);
            chk("stall_done", 32'(Done), 32'd0);
        end
        Stall = 0;
        cyc(1);
        chk("halt_done", 32'(Done), 32'd1);
        chk("halt_pc", 32'(PC), 32'h001);
        pulse_start();
        chk("restart_pc", 32'(PC), 32'd0);
        chk("restart_running", 32'(Running), 32'd1);

        // Call/return sequence
        lut_write(4'd3, 12'd10);
        pulse_start();
        cyc(10);
        call_lut(4'd3);
        cyc(10);
        call_lut(4'd3);
        cyc(10);
        chk("at50", 32'(PC), 32'd50);
        call_lut(4'd3);
        chk("call3_pc", 32'(PC), 32'd60);
`ifdef PCSEQ_RAS_EN
        chk("ras_overflow", 32'(Fault), 32'd1);
        ret_once(); chk("ret1", 32'(PC), 32'd31);
        ret_once(); chk("ret2", 32'(PC), 32'd11);
        ret_once(); chk("ret_empty", 32'(PC), 32'd12);
        chk("ret_empty_fault", 32'(Fault), 32'd1);
        pulse_start();
        chk("start_clr_fault", 32'(Fault), 32'd0);
`else
        chk("no_ras_fault", 32'(Fault), 32'd0);
        ret_once(); chk("ret_plain", 32'(PC), 32'd61);
        chk("ret_plain_fault", 32'(Fault), 32'd0);
`endif

        // Reset overrides Start
        cyc(3);
        clear_in(); Reset = 1; Start = 1;
        cyc(1);
        chk("rst_over_start_run", 32'(Running), 32'd0);
        chk("rst_over_start_pc", 32'(PC), 32'd0);
        Reset = 0;
        pulse_start();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            Reset    = ($urandom_range(63) == 0);
            Start    = ($urandom_range(31) == 0);
            Stall    = ($urandom_range(5) == 0);
            Halt     = ($urandom_range(19) == 0);
            Branch   = ($urandom_range(2) == 0);
            Taken    = 1'($urandom);
            ImmOrLUT = 1'($urandom);
            Field    = 4'($urandom);
            Call     = ($urandom_range(7) == 0);
            Ret      = ($urandom_range(7) == 0);
            LutWe    = ($urandom_range(3) == 0);
            LutWaddr = 4'($urandom);
            LutWdata = 12'($urandom);
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
